// File: rtl/guess_entry_ctrl.sv
// guess_entry_ctrl: keypad digit entry for secret/guess banks with a sequential bulls/cows compare.
// Optional macro UNIQUE_DIGIT_CHECK_EN rejects a digit already present in the active bank.
module guess_entry_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int RADIX = 10,
  parameter int GCNT_W = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               key_valid,
  input  logic [DIGIT_W-1:0]                 key_code,
  output logic [NUM_DIGITS*DIGIT_W-1:0]      secret_flat,
  output logic [NUM_DIGITS*DIGIT_W-1:0]      guess_flat,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    cursor,
  output logic [1:0]                         phase,
  output logic                               busy,
  output logic                               key_err,
  output logic                               result_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    a_count,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    b_count,
  output logic                               win,
  output logic [GCNT_W-1:0]                  guess_cnt
);
  localparam int CW = $clog2(NUM_DIGITS+1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);
  localparam logic [DIGIT_W-1:0] K_BACK = DIGIT_W'(RADIX);
  localparam logic [DIGIT_W-1:0] K_CLEAR = DIGIT_W'(RADIX+1);
  localparam logic [DIGIT_W-1:0] K_ENTER = DIGIT_W'(RADIX+2);
  typedef enum logic [1:0] {SECRET, GUESS, CHECK, DONE} state_t;
  state_t st;
  logic [DIGIT_W-1:0] secret [NUM_DIGITS];
  logic [DIGIT_W-1:0] guess [NUM_DIGITS];
  logic [DIGIT_W-1:0] g_cur, s_cur;
  logic [CW-1:0] idx, acc_a, acc_b, hit_b;
  logic hit_a, dup;
  assign phase = st;
  assign busy = st == CHECK;
  assign hit_a = g_cur == s_cur;
  // cows for the current index: guess digit against every other secret position
  always_comb begin
    secret_flat = '0;
    guess_flat = '0;
    g_cur = '0;
    s_cur = '0;
    hit_b = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      secret_flat[i*DIGIT_W +: DIGIT_W] = secret[i];
      guess_flat[i*DIGIT_W +: DIGIT_W] = guess[i];
      if (idx == CW'(i)) begin
        g_cur = guess[i];
        s_cur = secret[i];
      end
    end
    for (int j = 0; j < NUM_DIGITS; j++)
      if (idx != CW'(j) && g_cur == secret[j]) hit_b = hit_b + CW'(1);
  end
`ifdef UNIQUE_DIGIT_CHECK_EN
  always_comb begin
    dup = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (CW'(j) < cursor && key_code == (st == GUESS ? guess[j] : secret[j])) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        secret[i] <= '0;
        guess[i] <= '0;
      end
      st <= SECRET;
      cursor <= '0;
      key_err <= 1'b0;
      result_valid <= 1'b0;
      win <= 1'b0;
      a_count <= '0;
      b_count <= '0;
      guess_cnt <= '0;
      idx <= '0;
      acc_a <= '0;
      acc_b <= '0;
    end else begin
      key_err <= 1'b0;
      result_valid <= 1'b0;
      case (st)
        CHECK: begin
          if (idx == FULL) begin
            a_count <= acc_a;
            b_count <= acc_b;
            result_valid <= 1'b1;
            if (~&guess_cnt) guess_cnt <= guess_cnt + GCNT_W'(1);
            if (acc_a == FULL) begin
              win <= 1'b1;
              st <= DONE;
            end else begin
              st <= GUESS;
              cursor <= '0;
              for (int i = 0; i < NUM_DIGITS; i++) guess[i] <= '0;
            end
          end else begin
            acc_a <= acc_a + CW'(hit_a);
            acc_b <= acc_b + hit_b;
            idx <= idx + CW'(1);
          end
        end
        DONE: begin
          if (key_valid && key_code == K_CLEAR) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              secret[i] <= '0;
              guess[i] <= '0;
            end
            cursor <= '0;
            win <= 1'b0;
            guess_cnt <= '0;
            st <= SECRET;
          end
        end
        default: begin
          if (key_valid) begin
            if (key_code < K_BACK) begin
              if (cursor == FULL || dup) key_err <= 1'b1;
              else begin
                for (int i = 0; i < NUM_DIGITS; i++)
                  if (cursor == CW'(i)) begin
                    if (st == SECRET) secret[i] <= key_code;
                    else guess[i] <= key_code;
                  end
                cursor <= cursor + CW'(1);
              end
            end else if (key_code == K_BACK) begin
              if (cursor == '0) key_err <= 1'b1;
              else begin
                for (int i = 0; i < NUM_DIGITS; i++)
                  if (cursor == CW'(i+1)) begin
                    if (st == SECRET) secret[i] <= '0;
                    else guess[i] <= '0;
                  end
                cursor <= cursor - CW'(1);
              end
            end else if (key_code == K_CLEAR) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (st == SECRET) secret[i] <= '0;
                else guess[i] <= '0;
              end
              cursor <= '0;
            end else if (key_code == K_ENTER) begin
              if (cursor != FULL) key_err <= 1'b1;
              else if (st == SECRET) begin
                st <= GUESS;
                cursor <= '0;
                for (int i = 0; i < NUM_DIGITS; i++) guess[i] <= '0;
              end else begin
                st <= CHECK;
                idx <= '0;
                acc_a <= '0;
                acc_b <= '0;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_guess_entry_ctrl.sv
// tb_guess_entry_ctrl: directed and random keypad traffic checked every cycle against a key-level game model.
module tb_guess_entry_ctrl;
  localparam int N = 4, DW = 4, CW = 3, GW = 8;
  logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0;
  logic [DW-1:0] key_code = '0;
  logic [N*DW-1:0] secret_flat, guess_flat;
  logic [CW-1:0] cursor, a_count, b_count;
  logic [1:0] phase;
  logic busy, key_err, result_valid, win;
  logic [GW-1:0] guess_cnt;

  guess_entry_ctrl #(.NUM_DIGITS(N), .DIGIT_W(DW), .RADIX(10), .GCNT_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .secret_flat(secret_flat), .guess_flat(guess_flat), .cursor(cursor), .phase(phase),
    .busy(busy), .key_err(key_err), .result_valid(result_valid), .a_count(a_count),
    .b_count(b_count), .win(win), .guess_cnt(guess_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_bank [2][N];
  int m_cur, m_ph, m_a, m_b, m_gc, m_left, m_pa, m_pb;
  bit m_err, m_rv, m_win, m_dup;
  logic [N*DW-1:0] e_sec, e_gue;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) m_bank[b][i] = 0;
    m_cur = 0; m_ph = 0; m_a = 0; m_b = 0; m_gc = 0; m_left = 0;
    m_pa = 0; m_pb = 0; m_err = 0; m_rv = 0; m_win = 0;
  endfunction

  // key-level game rules; a compare is scored in one go at enter and released N+1 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      m_err = 0;
      m_rv = 0;
      if (m_ph == 2) begin
        if (m_left == 1) begin
          m_a = m_pa; m_b = m_pb; m_rv = 1;
          if (m_gc < 255) m_gc++;
          if (m_pa == N) begin m_win = 1; m_ph = 3; end
          else begin
            m_ph = 1; m_cur = 0;
            for (int i = 0; i < N; i++) m_bank[1][i] = 0;
          end
        end else m_left--;
      end else if (key_valid && int'(key_code) <= 12) begin
        if (m_ph == 3) begin
          if (key_code == 11) begin
            for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) m_bank[b][i] = 0;
            m_cur = 0; m_win = 0; m_gc = 0; m_ph = 0;
          end
        end else if (key_code < 10) begin
          m_dup = 0;
`ifdef UNIQUE_DIGIT_CHECK_EN
          for (int i = 0; i < m_cur; i++) if (m_bank[m_ph][i] == int'(key_code)) m_dup = 1;
`endif
          if (m_cur == N || m_dup) m_err = 1;
          else begin m_bank[m_ph][m_cur] = int'(key_code); m_cur++; end
        end else if (key_code == 10) begin
          if (m_cur == 0) m_err = 1;
          else begin m_cur--; m_bank[m_ph][m_cur] = 0; end
        end else if (key_code == 11) begin
          for (int i = 0; i < N; i++) m_bank[m_ph][i] = 0;
          m_cur = 0;
        end else begin
          if (m_cur != N) m_err = 1;
          else if (m_ph == 0) begin
            m_ph = 1; m_cur = 0;
            for (int i = 0; i < N; i++) m_bank[1][i] = 0;
          end else begin
            m_pa = 0; m_pb = 0;
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                if (m_bank[1][i] == m_bank[0][j]) begin
                  if (i == j) m_pa++;
                  else m_pb++;
                end
            m_ph = 2; m_left = N + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        e_sec[i*DW +: DW] = DW'(m_bank[0][i]);
        e_gue[i*DW +: DW] = DW'(m_bank[1][i]);
      end
      chk("secret_flat", int'(secret_flat), int'(e_sec));
      chk("guess_flat", int'(guess_flat), int'(e_gue));
      chk("cursor", cursor, m_cur);
      chk("phase", phase, m_ph);
      chk("busy", busy, int'(m_ph == 2));
      chk("key_err", key_err, m_err);
      chk("result_valid", result_valid, m_rv);
      chk("a_count", a_count, m_a);
      chk("b_count", b_count, m_b % (1 << CW));
      chk("win", win, m_win);
      chk("guess_cnt", guess_cnt, m_gc);
    end
  end

  task automatic press(int code);
    key_valid = 1'b1;
    key_code = DW'(code);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic type4(int d0, int d1, int d2, int d3);
    press(d0); press(d1); press(d2); press(d3);
  endtask

  task automatic wait_result(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (result_valid) begin n = k; break; end
    end
    if (n == 0) chk("result_timeout", 0, 1);
  endtask

  int n, r;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_flats", int'(secret_flat | guess_flat), 0);
    chk("rst_outs", int'({busy, key_err, result_valid, win, a_count, b_count, guess_cnt}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // reset dropped while a compare is in flight
    type4(1, 2, 3, 4); press(12);
    type4(1, 2, 4, 3); press(12);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_phase", phase, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_flats", int'(secret_flat | guess_flat), 0);
    chk("midrst_counts", int'({a_count, b_count, guess_cnt, cursor}), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_result", result_valid, 0);
    end
    rst_n = 1'b1;
    // winning guess and latency
    type4(1, 2, 3, 4); press(12);
    type4(1, 2, 3, 4); press(12);
    wait_result(n);
    chk("latency", n, 5);
    chk("win_a", a_count, 4);
    chk("win_b", b_count, 0);
    chk("win_flag", win, 1);
    chk("win_phase", phase, 3);
    chk("win_gcnt", guess_cnt, 1);
    press(11);
    chk("clear_done_phase", phase, 0);
    chk("clear_done_gcnt", guess_cnt, 0);
    // all cows, then near miss
    type4(1, 2, 3, 4); press(12);
    type4(4, 3, 2, 1); press(12);
    wait_result(n);
    chk("cows_a", a_count, 0);
    chk("cows_b", b_count, 4);
    chk("cows_win", win, 0);
    @(negedge clk);
    chk("cows_phase", phase, 1);
    chk("cows_cursor", cursor, 0);
    type4(1, 2, 3, 5); press(12);
    wait_result(n);
    chk("near_a", a_count, 3);
    chk("near_b", b_count, 0);
    chk("near_gcnt", guess_cnt, 2);
    @(negedge clk);
    // entry errors
    press(1); press(2); press(3); press(12);
    chk("short_enter_err", key_err, 1);
    chk("short_enter_phase", phase, 1);
    press(10); press(10);
    chk("back2_cursor", cursor, 1);
    press(10);
    chk("back_ok_err", key_err, 0);
    press(10);
    chk("back_empty_err", key_err, 1);
    type4(2, 1, 4, 3); press(9);
    chk("overflow_err", key_err, 1);
    chk("overflow_bank", int'(guess_flat), 'h3412);
    for (int c = 13; c <= 15; c++) begin
      press(c);
      chk("hi_code_guess", key_err, 0);
    end
    // keys while busy must not disturb the compare
    press(12); press(1); press(11); press(12); press(10);
    wait_result(n);
    chk("busy_keys_a", a_count, 0);
    chk("busy_keys_b", b_count, 4);
    @(negedge clk);
    type4(1, 2, 3, 4); press(12);
    wait_result(n);
    chk("done_again", phase, 3);
    for (int c = 13; c <= 15; c++) begin press(c); chk("hi_code_done", key_err, 0); end
    press(1); press(10); press(12);
    chk("done_other_err", key_err, 0);
    chk("done_other_phase", phase, 3);
    press(11);
    for (int c = 13; c <= 15; c++) begin press(c); chk("hi_code_secret", cursor, 0); end
    press(1); press(1);
`ifdef UNIQUE_DIGIT_CHECK_EN
    chk("dup_err", key_err, 1);
    chk("dup_cursor", cursor, 1);
    chk("dup_bank", int'(secret_flat), 'h0001);
`else
    chk("dup_cursor", cursor, 2);
    chk("dup_bank", int'(secret_flat), 'h0011);
`endif
    press(11);
    // random traffic with a narrow digit range so matches and wins occur
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        key_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      r = $urandom_range(0, 99);
      key_valid = 1'($urandom_range(0, 1));
      key_code = r < 55 ? DW'($urandom_range(0, 3)) : r < 65 ? DW'($urandom_range(0, 9)) :
                 r < 72 ? DW'(10) : r < 76 ? DW'(11) : r < 95 ? DW'(12) : DW'($urandom_range(13, 15));
      @(negedge clk);
    end
    key_valid = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
